// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared fetch-stage types and constants
package fetch_pkg;

  typedef enum logic [2:0] {
    REQ,
    WAIT,
    HOLD,
    DRAIN,
    FAULT
  } fetch_state_e;

  localparam logic [31:0] INSTR_BYTES = 32'd4;
  localparam logic [31:0] ALIGN_MASK  = 32'hFFFF_FFFC;

  function automatic logic is_aligned(input logic [31:0] addr);
    return (addr & ~ALIGN_MASK) == 32'd0;
  endfunction

endpackage

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - single-outstanding fetch sequencer driving the PC register and imem port
module pc_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_current,
  output logic        pc_load,
  output logic [31:0] pc_next,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        trap_valid,
  input  logic [31:0] trap_vector,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        misaligned_fault
);

  fetch_state_e state_q, state_d;
  logic         fault_pending_q, fault_pending_d;
  logic [31:0]  if_instr_q, if_instr_d;
  logic [31:0]  if_pc_q, if_pc_d;

  logic halted;
  logic take_branch;
  logic branch_ok;
  logic branch_bad;
  logic outstanding;

  // A pending misaligned fault (draining toward FAULT) ignores further branches too.
  always_comb begin
    halted      = (state_q == FAULT) || fault_pending_q;
    take_branch = redirect_valid && !trap_valid && !halted;
    branch_ok   = take_branch && is_aligned(redirect_target);
    branch_bad  = take_branch && !is_aligned(redirect_target);
    outstanding = ((state_q == WAIT) || (state_q == DRAIN)) && !imem_rvalid;
  end

  always_comb begin
    state_d          = state_q;
    fault_pending_d  = fault_pending_q;
    if_instr_d       = if_instr_q;
    if_pc_d          = if_pc_q;
    pc_load          = 1'b0;
    pc_next          = BOOT_ADDRESS;
    imem_req         = 1'b0;
    misaligned_fault = 1'b0;

    if (reset) begin
      state_d         = REQ;
      fault_pending_d = 1'b0;
      if_instr_d      = 32'd0;
      if_pc_d         = 32'd0;
    end else if (trap_valid || take_branch) begin
      fault_pending_d  = branch_bad;
      misaligned_fault = branch_bad;
      if (trap_valid) begin
        pc_load = 1'b1;
        pc_next = trap_vector & ALIGN_MASK;
      end else if (branch_ok) begin
        pc_load = 1'b1;
        pc_next = redirect_target;
      end
      // A response still owed by memory must be swallowed before anything else.
      if (outstanding) begin
        state_d = DRAIN;
      end else begin
        state_d = branch_bad ? FAULT : REQ;
      end
    end else begin
      case (state_q)
        REQ: begin
          imem_req = 1'b1;
          if (imem_gnt) begin
            state_d = WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            pc_load    = 1'b1;
            pc_next    = pc_current + INSTR_BYTES;
            if_instr_d = imem_rdata;
            if_pc_d    = pc_current;
            state_d    = HOLD;
          end
        end
        HOLD: begin
          if (if_ready) begin
            state_d = REQ;
          end
        end
        DRAIN: begin
          if (imem_rvalid) begin
            state_d         = fault_pending_q ? FAULT : REQ;
            fault_pending_d = 1'b0;
          end
        end
        FAULT: begin
          state_d = FAULT;
        end
        default: begin
          state_d = REQ;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    state_q         <= state_d;
    fault_pending_q <= fault_pending_d;
    if_instr_q      <= if_instr_d;
    if_pc_q         <= if_pc_d;
  end

  assign imem_addr = pc_current;
  assign if_valid  = (state_q == HOLD);
  assign if_instr  = if_instr_q;
  assign if_pc     = if_pc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - randomized bench for pc_sequencer against an architectural fetch-stream model
module tb_pc_sequencer;

  localparam logic [31:0] BOOT = 32'h0000_0000;
  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc_current = 32'd0;
  logic        pc_load;
  logic [31:0] pc_next;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'd0;
  logic        trap_valid = 1'b0;
  logic [31:0] trap_vector = 32'd0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        misaligned_fault;

  int n_tests = 0;
  int n_fail  = 0;

  // Architectural model: address of the next instruction decode must see.
  logic [31:0] m_pc = BOOT;
  bit          m_faulted = 1'b0;
  // Memory model: one pending response, live unless a redirect intervened.
  bit          mem_busy = 1'b0;
  bit          mem_live = 1'b0;
  logic [31:0] mem_addr = 32'd0;
  int          mem_cnt = 0;
  int          deliv_cnt = 0;
  logic [31:0] last_if_pc = 32'd0;
  bit          prev_hold = 1'b0;
  logic [31:0] prev_instr = 32'd0;
  logic [31:0] prev_pc = 32'd0;

  bit          nxt_reset = 1'b1;
  bit          nxt_redirect = 1'b0;
  bit          nxt_trap = 1'b0;
  bit          nxt_ready = 1'b1;
  logic [31:0] nxt_target = 32'd0;
  logic [31:0] nxt_vector = 32'd0;
  int          gnt_pct = 100;
  int          lat_max = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) pc_current <= BOOT;
    else if (pc_load) pc_current <= pc_next;
  end

  pc_sequencer #(.BOOT_ADDRESS(BOOT)) dut (
    .clk              (clk),
    .reset            (reset),
    .pc_current       (pc_current),
    .pc_load          (pc_load),
    .pc_next          (pc_next),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_gnt         (imem_gnt),
    .imem_rvalid      (imem_rvalid),
    .imem_rdata       (imem_rdata),
    .redirect_valid   (redirect_valid),
    .redirect_target  (redirect_target),
    .trap_valid       (trap_valid),
    .trap_vector      (trap_vector),
    .if_valid         (if_valid),
    .if_ready         (if_ready),
    .if_instr         (if_instr),
    .if_pc            (if_pc),
    .misaligned_fault (misaligned_fault)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    bit live_resp;
    @(posedge clk);
    #1;
    reset           = nxt_reset;
    redirect_valid  = nxt_redirect;
    redirect_target = nxt_target;
    trap_valid      = nxt_trap;
    trap_vector     = nxt_vector;
    if_ready        = nxt_ready;
    if (!nxt_reset && mem_busy && mem_cnt == 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(mem_addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    #1;
    imem_gnt = imem_req && ($urandom_range(1, 100) <= gnt_pct);
    nxt_redirect = 1'b0;
    nxt_trap     = 1'b0;
    @(negedge clk);

    if (reset) begin
      check_eq("rst_imem_req", imem_req, 0);
      check_eq("rst_pc_load", pc_load, 0);
      check_eq("rst_misaligned", misaligned_fault, 0);
      mem_busy  = 1'b0;
      mem_live  = 1'b0;
      m_pc      = BOOT;
      m_faulted = 1'b0;
      prev_hold = 1'b0;
      return;
    end

    if (prev_hold) begin
      check_eq("stall_if_valid", if_valid, 1);
      check_eq("stall_if_instr", if_instr, prev_instr);
      check_eq("stall_if_pc", if_pc, prev_pc);
    end
    if (m_faulted) begin
      check_eq("fault_imem_req", imem_req, 0);
      check_eq("fault_if_valid", if_valid, 0);
    end
    if (if_valid) check_eq("hold_no_req", imem_req, 0);

    live_resp = imem_rvalid && mem_live;
    if (trap_valid) begin
      check_eq("trap_pc_load", pc_load, 1);
      check_eq("trap_pc_next", pc_next, trap_vector & WORD_MASK);
      check_eq("trap_misaligned", misaligned_fault, 0);
      check_eq("trap_imem_req", imem_req, 0);
    end else if (redirect_valid && !m_faulted) begin
      check_eq("redir_imem_req", imem_req, 0);
      if (redirect_target[1:0] == 2'b00) begin
        check_eq("redir_pc_load", pc_load, 1);
        check_eq("redir_pc_next", pc_next, redirect_target);
        check_eq("redir_misaligned", misaligned_fault, 0);
      end else begin
        check_eq("misalign_pulse", misaligned_fault, 1);
        check_eq("misalign_pc_load", pc_load, 0);
      end
    end else begin
      check_eq("quiet_misaligned", misaligned_fault, 0);
      check_eq("incr_pc_load", pc_load, live_resp);
      if (live_resp) check_eq("incr_pc_next", pc_next, m_pc + 32'd4);
    end

    if (if_valid && if_ready) begin
      check_eq("if_pc", if_pc, m_pc);
      check_eq("if_instr", if_instr, mem_word(m_pc));
      last_if_pc = if_pc;
      m_pc = m_pc + 32'd4;
      deliv_cnt++;
    end
    prev_hold  = if_valid && !if_ready && !trap_valid && !(redirect_valid && !m_faulted);
    prev_instr = if_instr;
    prev_pc    = if_pc;

    if (trap_valid) begin
      m_pc      = trap_vector & WORD_MASK;
      m_faulted = 1'b0;
      mem_live  = 1'b0;
    end else if (redirect_valid && !m_faulted) begin
      mem_live = 1'b0;
      if (redirect_target[1:0] == 2'b00) m_pc = redirect_target;
      else m_faulted = 1'b1;
    end

    if (imem_rvalid) begin
      mem_busy = 1'b0;
      mem_live = 1'b0;
    end else if (mem_busy) begin
      mem_cnt--;
    end
    if (imem_req && imem_gnt) begin
      check_eq("one_outstanding", mem_busy, 0);
      check_eq("fetch_addr", imem_addr, m_pc);
      mem_busy = 1'b1;
      mem_live = 1'b1;
      mem_addr = imem_addr;
      mem_cnt  = $urandom_range(0, lat_max);
    end
  endtask

  task automatic wait_delivery(input string tag, input int max_cycles);
    int start;
    int n;
    start = deliv_cnt;
    n = 0;
    while (deliv_cnt == start && n < max_cycles) begin
      cycle();
      n++;
    end
    check_eq(tag, deliv_cnt != start, 1);
  endtask

  initial begin
    int loads;
    int d0;
    int r;
    logic [31:0] saved_pc;

    nxt_reset = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    check_eq("rst_if_valid", if_valid, 0);
    check_eq("rst_if_instr", if_instr, 0);
    check_eq("rst_if_pc", if_pc, 0);

    // Zero-wait boot: REQ, WAIT, HOLD.
    nxt_reset = 1'b0;
    cycle();
    check_eq("boot_req", imem_req, 1);
    check_eq("boot_addr", imem_addr, 32'h0);
    cycle();
    check_eq("boot_pc_next", pc_next, 32'h4);
    cycle();
    check_eq("boot_if_valid", if_valid, 1);
    check_eq("boot_if_pc", if_pc, 32'h0);
    check_eq("boot_if_instr", if_instr, 32'h0000_0013);
    cycle();
    check_eq("boot_next_req", imem_req, 1);
    check_eq("boot_next_addr", imem_addr, 32'h4);

    nxt_ready = 1'b0;
    loads = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      loads += int'(pc_load);
    end
    check_eq("stall_one_load", loads, 1);
    check_eq("stall_still_valid", if_valid, 1);
    nxt_ready = 1'b1;

    nxt_trap = 1'b1;
    nxt_vector = 32'h80;
    nxt_redirect = 1'b1;
    nxt_target = 32'h200;
    cycle();
    check_eq("both_pc_next", pc_next, 32'h80);
    wait_delivery("both_deliver", 20);
    check_eq("both_first_pc", last_if_pc, 32'h80);

    wait_delivery("pre_misalign", 20);
    saved_pc = pc_current;
    nxt_redirect = 1'b1;
    nxt_target = 32'h102;
    cycle();
    check_eq("misalign_seen", misaligned_fault, 1);
    for (int i = 0; i < 10; i++) cycle();
    check_eq("misalign_pc_kept", pc_current, saved_pc);
    nxt_trap = 1'b1;
    nxt_vector = 32'h83;
    cycle();
    wait_delivery("trap83_deliver", 20);
    check_eq("trap83_pc", last_if_pc, 32'h80);

    nxt_trap = 1'b1;
    nxt_vector = 32'hFFFF_FFFC;
    cycle();
    wait_delivery("wrap_deliver", 20);
    check_eq("wrap_last", last_if_pc, 32'hFFFF_FFFC);
    wait_delivery("wrap_deliver2", 20);
    check_eq("wrap_zero", last_if_pc, 32'h0);

    gnt_pct = 60;
    lat_max = 3;
    d0 = deliv_cnt;
    for (int i = 0; i < 4000; i++) begin
      nxt_ready = ($urandom_range(0, 3) != 0);
      nxt_reset = (i == 2000 || i == 2001);
      r = $urandom_range(0, 99);
      if (r < 2) begin
        nxt_trap = 1'b1;
        nxt_vector = $urandom;
        nxt_redirect = ($urandom_range(0, 1) == 1);
        nxt_target = $urandom;
      end else if (r < 7) begin
        nxt_redirect = 1'b1;
        nxt_target = $urandom;
        if ($urandom_range(0, 4) != 0) nxt_target = nxt_target & WORD_MASK;
      end
      cycle();
    end
    check_eq("random_progress", (deliv_cnt - d0) > 100, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch-stage controller that sequences the core's program-counter register and the instruction-memory port. It issues one instruction fetch at a time and hands each fetched word to decode over a valid/ready handshake. It also advances the PC, applies branch/jump redirects and trap redirects, and drops responses that a redirect has made stale. It is instantiated at core level beside the PC register, which it drives through that register's load strobe and data input.

## Interface
- BOOT_ADDRESS, 32'h00000000: first fetch address after reset; must equal the PC register's reset value.
- clk  in  1  core clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- pc_current  in  32  PC register output.
- pc_load  out  1  PC load strobe.
- pc_next  out  32  PC load value; meaningful only when pc_load=1.
- imem_req  out  1  fetch request; held until granted.
- imem_addr  out  32  fetch address; equals pc_current.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  read data valid; exactly one per grant, at least 1 cycle after the grant.
- imem_rdata  in  32  instruction word.
- redirect_valid  in  1  branch/jump taken (1-cycle pulse).
- redirect_target  in  32  redirect address.
- trap_valid  in  1  trap/exception taken (1-cycle pulse).
- trap_vector  in  32  trap handler address.
- if_valid  out  1  instruction available to decode (registered).
- if_ready  in  1  decode accepts.
- if_instr  out  32  fetched word.
- if_pc  out  32  address of if_instr.
- misaligned_fault  out  1  1-cycle pulse; redirect target not word-aligned.

## Operation
- States:
  - REQ: imem_req=1.
  - WAIT: granted, awaiting rvalid.
  - HOLD: if_valid=1, awaiting if_ready.
  - DRAIN: discard one stale rvalid.
  - FAULT: halted until a trap.
- Transitions:
  - REQ→WAIT on imem_gnt.
  - WAIT→HOLD on imem_rvalid. In that cycle, capture if_instr=imem_rdata and if_pc=pc_current, and assert pc_load with pc_next=pc_current+4 (mod 2^32).
  - HOLD→REQ when if_valid and if_ready.
  - DRAIN→REQ on imem_rvalid; the data is discarded.
- Redirect handling:
  - A trap redirect applies when trap_valid=1; it applies trap_vector.
  - A branch redirect applies when redirect_valid=1 and trap_valid=0; it applies redirect_target. Trap wins when both are asserted.
  - Either redirect asserts pc_load with pc_next=target in the same cycle.
  - imem_req is forced 0 in the redirect cycle.
  - if_valid clears on the next edge.
- Next state after a redirect:
  - DRAIN if a grant is outstanding, i.e. state WAIT without rvalid this cycle.
  - Otherwise REQ, including:
    - REQ without gnt;
    - WAIT with rvalid in the same cycle, where the response is dropped and the PC is not incremented;
    - HOLD;
    - DRAIN with rvalid this cycle.
  - A redirect in DRAIN without rvalid stays in DRAIN.
- Alignment:
  - A branch redirect_target with [1:0]≠0 pulses misaligned_fault, does not load the PC, and enters FAULT (via DRAIN first if a grant is outstanding).
  - trap_vector[1:0] are forced to 0 before loading.
- FAULT: imem_req=0 and if_valid=0. Only trap_valid leaves it, to REQ.
- A handshake (if_valid and if_ready) in a redirect cycle still completes. Killing that instruction is decode's job, using redirect_valid or trap_valid.

## Timing
- Reset:
  - State REQ.
  - if_valid=0, if_instr=0, if_pc=0.
  - pc_load=0 and misaligned_fault=0.
  - imem_req=0 while reset=1; imem_req=1 in the first cycle after release, with imem_addr=BOOT_ADDRESS.
- Reset mid-operation aborts any state immediately. The instruction memory shares this reset, so no stale rvalid follows.
- Zero-wait memory (gnt in the request cycle, rvalid the next cycle) with if_ready=1 gives one instruction per 3 cycles: REQ, WAIT, HOLD.
- pc_load is combinational from state and inputs and is asserted for exactly one cycle per increment or redirect.
- At most one fetch is outstanding.
- imem_addr is stable while imem_req=1 and not granted.

## Structure
- Shared package fetch_pkg holds:
  - the state enum (REQ, WAIT, HOLD, DRAIN, FAULT);
  - INSTR_BYTES=4;
  - the alignment-mask constant.
- Single flat module; no sub-module. The existing PC register stays a separate instance at core level.

## Test plan
- Reset release with BOOT_ADDRESS=0 and zero-wait memory returning 0x00000013 → imem_addr=0x0 at cycle 1; if_valid at cycle 3 with if_pc=0x0 and if_instr=0x00000013; next request at 0x4.
- Hold if_ready=0 for 5 cycles → if_valid and if_instr stable, no new imem_req, pc_load asserted only once.
- redirect_valid with target 0x100 while in WAIT, rvalid 2 cycles later → stale word not presented; next imem_addr=0x100; first if_pc=0x100.
- trap_valid (vector 0x80) and redirect_valid (target 0x200) in the same cycle → pc_next=0x80; fetch resumes at 0x80.
- redirect_target=0x102 → misaligned_fault pulses once; PC unchanged; no fetch. Then trap_vector=0x83 → fetch at 0x80.
- pc_current=0xFFFFFFFC with a fetch completing → pc_next=0x00000000.
